// File: rtl/npu_cmp_pkg.sv
// Shared definitions for the compressor-tree / unary-expansion datapath.
package npu_cmp_pkg;
  localparam int N_BITS_DEF = 10;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/thermo_decode.sv
// Combinational count-to-thermometer decoder with clamp to N_BITS and a saturate flag.
module thermo_decode
  import npu_cmp_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]  i_cnt,
  output logic [N_BITS-1:0] o_thermo,
  output logic              o_sat
);
  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(N_BITS);

  logic [CNT_W-1:0] w_clamped;

  always_comb begin
    o_sat     = (i_cnt > LP_MAX);
    w_clamped = o_sat ? LP_MAX : i_cnt;
    o_thermo  = '0;
    for (int i = 0; i < N_BITS; i++) begin
      o_thermo[i] = (CNT_W'(i) < w_clamped);
    end
  end
endmodule

// File: rtl/thermo_expander.sv
// Expands a population count into a thermometer word and an LSB-first unary bit stream,
// with a back-to-back reload on the last beat for full throughput.
module thermo_expander
  import npu_cmp_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic [N_BITS-1:0] out_thermo,
  output logic              sat_err,
  input  logic              err_clr
);
  generate
    if ((N_BITS > (2 ** CNT_W) - 1) || (N_BITS < 2)) begin : g_bad_width
      $error("thermo_expander: N_BITS must be in 2..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_BITS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_BITS-1:0]  r_shreg;
  logic [N_BITS-1:0]  r_thermo;
  logic [CNT_W-1:0]   r_beat;
  logic               r_sat;
  logic [N_BITS-1:0]  w_thermo;
  logic               w_sat;
  logic               w_last;
  logic               w_accept;
  logic               w_advance;

  thermo_decode #(
    .N_BITS (N_BITS),
    .CNT_W  (CNT_W)
  ) u_decode (
    .i_cnt    (in_cnt),
    .o_thermo (w_thermo),
    .o_sat    (w_sat)
  );

  assign w_last    = (r_state == ST_SHIFT) && (r_beat == LP_LAST);
  // Only combinational out_ready -> in_ready path: lets the next frame load on the last beat.
  assign in_ready  = (r_state == ST_IDLE) || (w_last && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_advance = (r_state == ST_SHIFT) && out_ready && !w_last;

  assign out_valid  = (r_state == ST_SHIFT);
  assign out_bit    = (r_state == ST_SHIFT) && r_shreg[0];
  assign out_last   = w_last;
  assign out_thermo = r_thermo;
  assign sat_err    = r_sat;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && out_ready && !in_valid) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_thermo <= '0;
      r_beat   <= '0;
    end else if (w_accept) begin
      r_shreg  <= w_thermo;
      r_thermo <= w_thermo;
      r_beat   <= '0;
    end else if (w_advance) begin
      r_shreg  <= {1'b0, r_shreg[N_BITS-1:1]};
      r_beat   <= r_beat + CNT_W'(1);
    end
  end

  // A saturating accept outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_sat <= 1'b0;
    else if (w_accept && w_sat) r_sat <= 1'b1;
    else if (err_clr)         r_sat <= 1'b0;
  end
endmodule
